slurm16_cpu_interlock: RTL and testbench

Pipeline interlock controller for the slurm16 CPU. Owns the hazard shadow pipeline: it carries the p0 hazard register and flag-hazard bit through slots p1–p3 and feeds them back to the combinational hazard unit. It uses the hazard unit's `hazard_1..3` results, memory wait and branch flush to decide when to stall p0, when to inject a bubble into p1, and how to shift the shadow slots. It sits beside the hazard unit in the CPU pipeline and drives the fetch/decode hold and bubble-insert controls.

---
 rtl/slurm16_cpu_interlock_pkg.sv | 18 +
 rtl/slurm16_cpu_interlock_if.sv | 37 +++
 rtl/slurm16_cpu_interlock_hazard_shadow.sv | 44 ++++
 rtl/slurm16_cpu_interlock.sv | 132 +++++++++++++
 tb/tb_slurm16_cpu_interlock.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/slurm16_cpu_interlock_pkg.sv
// Shared slurm16 interlock definitions: the no-hazard register, FSM encoding and slot width.
package slurm16_cpu_defs;

    localparam int DEFAULT_REGISTER_BITS = 7;
    localparam int R0 = 0;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_INTERLOCK = 2'd1,
        ST_HOLD      = 2'd2
    } ilk_state_t;

    // A slot carries the destination register plus the flag-hazard bit.
    function automatic int slot_width(input int register_bits);
        return register_bits + 1;
    endfunction

endpackage

// File: rtl/slurm16_cpu_interlock_if.sv
// Hazard-unit / pipeline-control bus between the slurm16 interlock and its neighbours.
interface slurm16_cpu_interlock_if #(
    parameter int REGISTER_BITS = 7
);
    logic                     p0_valid;
    logic [REGISTER_BITS-1:0] hazard_reg0;
    logic                     modifies_flags0;
    logic                     hazard_1;
    logic                     hazard_2;
    logic                     hazard_3;
    logic                     mem_wait;
    logic                     flush;
    logic [REGISTER_BITS-1:0] hazard_reg1;
    logic [REGISTER_BITS-1:0] hazard_reg2;
    logic [REGISTER_BITS-1:0] hazard_reg3;
    logic                     modifies_flags1;
    logic                     modifies_flags2;
    logic                     modifies_flags3;
    logic                     stall_p0;
    logic                     bubble_p1;

    modport master (
        output p0_valid, hazard_reg0, modifies_flags0,
        output hazard_1, hazard_2, hazard_3, mem_wait, flush,
        input  hazard_reg1, hazard_reg2, hazard_reg3,
        input  modifies_flags1, modifies_flags2, modifies_flags3,
        input  stall_p0, bubble_p1
    );

    modport slave (
        input  p0_valid, hazard_reg0, modifies_flags0,
        input  hazard_1, hazard_2, hazard_3, mem_wait, flush,
        output hazard_reg1, hazard_reg2, hazard_reg3,
        output modifies_flags1, modifies_flags2, modifies_flags3,
        output stall_p0, bubble_p1
    );
endinterface

// File: rtl/slurm16_cpu_interlock_hazard_shadow.sv
// Three-deep hazard shadow shift register: hold freezes all, kill zeroes slots 1-2,
// bubble zeroes slot1 while the rest shift.
module slurm16_hazard_shadow
    import slurm16_cpu_defs::*;
#(
    parameter int SLOT_BITS = slot_width(DEFAULT_REGISTER_BITS)
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic                 hold,
    input  logic                 kill,
    input  logic                 bubble,
    input  logic [SLOT_BITS-1:0] slot_in,
    output logic [SLOT_BITS-1:0] slot1,
    output logic [SLOT_BITS-1:0] slot2,
    output logic [SLOT_BITS-1:0] slot3
);

    logic [SLOT_BITS-1:0] slot_reg  [1:3];
    logic [SLOT_BITS-1:0] slot_next [1:3];

    assign slot_next[1] = hold ? slot_reg[1] : ((kill || bubble) ? '0 : slot_in);

    // A kill clears slot2 too; slot3 still receives the old slot2 so it retires.
    generate
        for (genvar gi = 2; gi <= 3; gi++) begin : g_shift
            assign slot_next[gi] = hold ? slot_reg[gi]
                                 : ((kill && (gi == 2)) ? '0 : slot_reg[gi-1]);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 1; i <= 3; i++) slot_reg[i] <= '0;
        end else begin
            for (int i = 1; i <= 3; i++) slot_reg[i] <= slot_next[i];
        end
    end

    assign slot1 = slot_reg[1];
    assign slot2 = slot_reg[2];
    assign slot3 = slot_reg[3];

endmodule

// File: rtl/slurm16_cpu_interlock.sv
// slurm16 pipeline interlock: FSM, stall/bubble priority, error flag and optional
// stall counter (enabled by defining SLURM16_STALL_COUNT_EN).
module slurm16_cpu_interlock
    import slurm16_cpu_defs::*;
#(
    parameter int REGISTER_BITS = DEFAULT_REGISTER_BITS,
    parameter int MAX_INTERLOCK = 3
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    slurm16_cpu_interlock_if.slave ilk,
    output logic                   interlock_err
`ifdef SLURM16_STALL_COUNT_EN
    ,
    input  logic                   stall_count_clr,
    output logic [15:0]            stall_count
`endif
);

    localparam int SLOT_BITS = slot_width(REGISTER_BITS);

    ilk_state_t           state_reg, state_next;
    logic                 flush_pend_reg, flush_pend_next;
    logic [1:0]           ilk_cnt_reg, ilk_cnt_next;
    logic                 interlock_err_reg, interlock_err_next;
    logic                 hz, flush_any;
    logic                 do_hold, do_kill, do_bubble;
    logic [SLOT_BITS-1:0] slot_in, slot1, slot2, slot3;

    assign hz        = ilk.p0_valid & (ilk.hazard_1 | ilk.hazard_2 | ilk.hazard_3);
    assign flush_any = ilk.flush | flush_pend_reg;
    assign slot_in   = ilk.p0_valid ? {ilk.hazard_reg0, ilk.modifies_flags0} : '0;

    // One action per cycle: mem_wait, then flush (live or pending), then hazard, else advance.
    always_comb begin
        do_hold         = 1'b0;
        do_kill         = 1'b0;
        do_bubble       = 1'b0;
        flush_pend_next = flush_pend_reg;
        ilk_cnt_next    = ilk_cnt_reg;
        if (ilk.mem_wait) begin
            do_hold = 1'b1;
            if (ilk.flush) flush_pend_next = 1'b1;
        end else if (flush_any) begin
            do_kill         = 1'b1;
            flush_pend_next = 1'b0;
        end else if (hz) begin
            do_bubble = 1'b1;
            if (ilk_cnt_reg != 2'b11) ilk_cnt_next = ilk_cnt_reg + 2'd1;
        end else begin
            ilk_cnt_next = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (ilk.mem_wait)          state_next = ST_HOLD;
                else if (hz && !flush_any) state_next = ST_INTERLOCK;
            end
            ST_INTERLOCK: begin
                if (ilk.mem_wait)          state_next = ST_HOLD;
                else if (!hz || flush_any) state_next = ST_RUN;
            end
            ST_HOLD: begin
                if (!ilk.mem_wait)
                    state_next = (hz && !flush_any) ? ST_INTERLOCK : ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Bubbles clear any real dependency within three cycles, so a longer run is a fault.
    assign interlock_err_next = interlock_err_reg | (hz && (int'(ilk_cnt_reg) == MAX_INTERLOCK));

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_reg         <= ST_RUN;
            flush_pend_reg    <= 1'b0;
            ilk_cnt_reg       <= '0;
            interlock_err_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            flush_pend_reg    <= flush_pend_next;
            ilk_cnt_reg       <= ilk_cnt_next;
            interlock_err_reg <= interlock_err_next;
        end
    end

    assign ilk.stall_p0  = RSTb & (do_hold | do_bubble);
    assign ilk.bubble_p1 = RSTb & (do_kill | do_bubble);
    assign interlock_err = interlock_err_reg;

    slurm16_hazard_shadow #(
        .SLOT_BITS (SLOT_BITS)
    ) u_shadow (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .hold    (do_hold),
        .kill    (do_kill),
        .bubble  (do_bubble),
        .slot_in (slot_in),
        .slot1   (slot1),
        .slot2   (slot2),
        .slot3   (slot3)
    );

    assign {ilk.hazard_reg1, ilk.modifies_flags1} = slot1;
    assign {ilk.hazard_reg2, ilk.modifies_flags2} = slot2;
    assign {ilk.hazard_reg3, ilk.modifies_flags3} = slot3;

`ifdef SLURM16_STALL_COUNT_EN
    logic [15:0] stall_count_reg, stall_count_next;

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_count_clr)
            stall_count_next = '0;
        else if (do_bubble && (stall_count_reg != 16'hFFFF))
            stall_count_next = stall_count_reg + 16'd1;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) stall_count_reg <= '0;
        else       stall_count_reg <= stall_count_next;
    end

    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_slurm16_cpu_interlock.sv
// Directed bench for slurm16_cpu_interlock: RAW/flag interlocks, flush, mem_wait, fault and reset.
module tb_slurm16_cpu_interlock;

    logic CLK = 1'b0;
    logic RSTb;
    logic interlock_err;
    int   checks = 0;
    int   passed = 0;

    slurm16_cpu_interlock_if #(.REGISTER_BITS(7)) bus ();

`ifdef SLURM16_STALL_COUNT_EN
    logic        stall_count_clr;
    logic [15:0] stall_count;
`endif

    slurm16_cpu_interlock #(
        .REGISTER_BITS (7),
        .MAX_INTERLOCK (3)
    ) dut (
        .CLK           (CLK),
        .RSTb          (RSTb),
        .ilk           (bus.slave),
        .interlock_err (interlock_err)
`ifdef SLURM16_STALL_COUNT_EN
        ,
        .stall_count_clr (stall_count_clr),
        .stall_count     (stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic [6:0] r, input logic f,
                         input logic h1, input logic h2, input logic h3,
                         input logic mw, input logic fl);
        bus.p0_valid        = v;
        bus.hazard_reg0     = r;
        bus.modifies_flags0 = f;
        bus.hazard_1        = h1;
        bus.hazard_2        = h2;
        bus.hazard_3        = h3;
        bus.mem_wait        = mw;
        bus.flush           = fl;
        #1;
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        #1;
        $display("%s: stall=%0b bubble=%0b r1=%0d r2=%0d r3=%0d f123=%0b%0b%0b err=%0b", tag,
                 bus.stall_p0, bus.bubble_p1, bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3,
                 bus.modifies_flags1, bus.modifies_flags2, bus.modifies_flags3, interlock_err);
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        drive(1, 7'd5, 1, 1, 1, 1, 0, 0);
        tick("reset");
        checks++; if (bus.stall_p0 !== 1'b0) $display("FAIL rst_stall got=%0b exp=0", bus.stall_p0); else passed++;
        checks++; if (bus.bubble_p1 !== 1'b0) $display("FAIL rst_bubble got=%0b exp=0", bus.bubble_p1); else passed++;
        checks++; if ({bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3} !== 21'd0)
            $display("FAIL rst_slots got=%0d/%0d/%0d exp=0/0/0", bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3); else passed++;
        checks++; if (bus.modifies_flags1 !== 1'b0) $display("FAIL rst_flag1 got=%0b exp=0", bus.modifies_flags1); else passed++;
        checks++; if (interlock_err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", interlock_err); else passed++;
        RSTb = 1'b1;
        drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_raw_slot1();
        drive(1, 7'd5, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_p0 !== 1'b0) $display("FAIL raw_a_stall got=%0b exp=0", bus.stall_p0); else passed++;
        tick("raw advance");
        checks++; if (bus.hazard_reg1 !== 7'd5) $display("FAIL raw_a_r1 got=%0d exp=5", bus.hazard_reg1); else passed++;
        drive(1, 7'd9, 0, 1, 0, 0, 0, 0);
        checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b11)
            $display("FAIL raw_b_ctl got=%0b%0b exp=11", bus.stall_p0, bus.bubble_p1); else passed++;
        tick("raw stall1");
        checks++; if ({bus.hazard_reg1, bus.hazard_reg2} !== {7'd0, 7'd5})
            $display("FAIL raw_b_slots got=%0d/%0d exp=0/5", bus.hazard_reg1, bus.hazard_reg2); else passed++;
        drive(1, 7'd9, 0, 0, 1, 0, 0, 0);
        checks++; if (bus.stall_p0 !== 1'b1) $display("FAIL raw_c_stall got=%0b exp=1", bus.stall_p0); else passed++;
        tick("raw stall2");
        checks++; if ({bus.hazard_reg2, bus.hazard_reg3} !== {7'd0, 7'd5})
            $display("FAIL raw_c_slots got=%0d/%0d exp=0/5", bus.hazard_reg2, bus.hazard_reg3); else passed++;
        drive(1, 7'd9, 0, 0, 0, 1, 0, 0);
        checks++; if (bus.stall_p0 !== 1'b1) $display("FAIL raw_d_stall got=%0b exp=1", bus.stall_p0); else passed++;
        tick("raw stall3");
        checks++; if (bus.hazard_reg3 !== 7'd0) $display("FAIL raw_d_r3 got=%0d exp=0", bus.hazard_reg3); else passed++;
        checks++; if (interlock_err !== 1'b0) $display("FAIL raw_d_err got=%0b exp=0", interlock_err); else passed++;
        drive(1, 7'd9, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b00)
            $display("FAIL raw_e_ctl got=%0b%0b exp=00", bus.stall_p0, bus.bubble_p1); else passed++;
        tick("raw release");
        checks++; if (bus.hazard_reg1 !== 7'd9) $display("FAIL raw_e_r1 got=%0d exp=9", bus.hazard_reg1); else passed++;
    endtask

    task automatic test_flag_hazard();
        drive(1, 7'd0, 1, 0, 0, 0, 0, 0);
        tick("flag advance");
        checks++; if ({bus.modifies_flags1, bus.hazard_reg2} !== {1'b1, 7'd9})
            $display("FAIL flag_a got=%0b/%0d exp=1/9", bus.modifies_flags1, bus.hazard_reg2); else passed++;
        drive(1, 7'd2, 0, 1, 0, 0, 0, 0);
        checks++; if (bus.stall_p0 !== 1'b1) $display("FAIL flag_b_stall got=%0b exp=1", bus.stall_p0); else passed++;
        tick("flag stall1");
        checks++; if ({bus.modifies_flags1, bus.modifies_flags2} !== 2'b01)
            $display("FAIL flag_b got=%0b%0b exp=01", bus.modifies_flags1, bus.modifies_flags2); else passed++;
        drive(1, 7'd2, 0, 0, 1, 0, 0, 0);
        tick("flag stall2");
        checks++; if ({bus.modifies_flags2, bus.modifies_flags3} !== 2'b01)
            $display("FAIL flag_c got=%0b%0b exp=01", bus.modifies_flags2, bus.modifies_flags3); else passed++;
        drive(1, 7'd2, 0, 0, 0, 1, 0, 0);
        checks++; if (bus.stall_p0 !== 1'b1) $display("FAIL flag_d_stall got=%0b exp=1", bus.stall_p0); else passed++;
        tick("flag stall3");
        checks++; if (bus.modifies_flags3 !== 1'b0) $display("FAIL flag_d got=%0b exp=0", bus.modifies_flags3); else passed++;
        drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.stall_p0 !== 1'b0) $display("FAIL flag_r_stall got=%0b exp=0", bus.stall_p0); else passed++;
        tick("flag release");
    endtask

    task automatic test_flush_interlock();
        drive(1, 7'd3, 0, 0, 0, 0, 0, 0);
        tick("flush setup1");
        drive(1, 7'd4, 0, 0, 0, 0, 0, 0);
        tick("flush setup2");
        checks++; if ({bus.hazard_reg1, bus.hazard_reg2} !== {7'd4, 7'd3})
            $display("FAIL fl_setup got=%0d/%0d exp=4/3", bus.hazard_reg1, bus.hazard_reg2); else passed++;
        drive(1, 7'd4, 0, 1, 0, 0, 0, 1);
        checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b01)
            $display("FAIL fl_ctl got=%0b%0b exp=01", bus.stall_p0, bus.bubble_p1); else passed++;
        tick("flush+hz");
        checks++; if ({bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3} !== {7'd0, 7'd0, 7'd3})
            $display("FAIL fl_slots got=%0d/%0d/%0d exp=0/0/3", bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3); else passed++;
        drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b00)
            $display("FAIL fl_after_ctl got=%0b%0b exp=00", bus.stall_p0, bus.bubble_p1); else passed++;
        tick("flush after");
        checks++; if (bus.hazard_reg3 !== 7'd0) $display("FAIL fl_after_r3 got=%0d exp=0", bus.hazard_reg3); else passed++;
    endtask

    task automatic test_mem_wait_flush();
        drive(1, 7'd6, 0, 0, 0, 0, 0, 0); tick("mw setup1");
        drive(1, 7'd7, 0, 0, 0, 0, 0, 0); tick("mw setup2");
        drive(1, 7'd8, 0, 0, 0, 0, 0, 0); tick("mw setup3");
        for (int k = 1; k <= 4; k++) begin
            drive(1, 7'd11, 0, (k == 3), 0, 0, 1, (k == 2));
            checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b10)
                $display("FAIL mw_ctl%0d got=%0b%0b exp=10", k, bus.stall_p0, bus.bubble_p1); else passed++;
            tick($sformatf("mw hold%0d", k));
            checks++; if ({bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3} !== {7'd8, 7'd7, 7'd6})
                $display("FAIL mw_slots%0d got=%0d/%0d/%0d exp=8/7/6", k, bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3); else passed++;
        end
        drive(1, 7'd12, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b01)
            $display("FAIL mw_pend_ctl got=%0b%0b exp=01", bus.stall_p0, bus.bubble_p1); else passed++;
        tick("mw pending flush");
        checks++; if ({bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3} !== {7'd0, 7'd0, 7'd7})
            $display("FAIL mw_pend_slots got=%0d/%0d/%0d exp=0/0/7", bus.hazard_reg1, bus.hazard_reg2, bus.hazard_reg3); else passed++;
        drive(1, 7'd12, 0, 0, 0, 0, 0, 0);
        checks++; if ({bus.stall_p0, bus.bubble_p1} !== 2'b00)
            $display("FAIL mw_resume_ctl got=%0b%0b exp=00", bus.stall_p0, bus.bubble_p1); else passed++;
        tick("mw resume");
        checks++; if (bus.hazard_reg1 !== 7'd12) $display("FAIL mw_resume_r1 got=%0d exp=12", bus.hazard_reg1); else passed++;
    endtask

    task automatic test_fault_and_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 7'd12, 0, 1, 0, 0, 0, 0);
            checks++; if (bus.stall_p0 !== 1'b1) $display("FAIL fault_stall%0d got=%0b exp=1", k, bus.stall_p0); else passed++;
            tick($sformatf("fault cycle%0d", k));
            checks++; if (interlock_err !== (k >= 4))
                $display("FAIL fault_err%0d got=%0b exp=%0b", k, interlock_err, (k >= 4)); else passed++;
        end
        RSTb = 1'b0;
        #1;
        checks++; if ({bus.stall_p0, bus.bubble_p1, interlock_err} !== 3'b000)
            $display("FAIL async_rst got=%0b%0b%0b exp=000", bus.stall_p0, bus.bubble_p1, interlock_err); else passed++;
        tick("held in reset");
        RSTb = 1'b1;
        drive(1, 7'd14, 0, 0, 0, 0, 0, 0);
        tick("post reset advance");
        checks++; if (bus.hazard_reg1 !== 7'd14) $display("FAIL prst_r1 got=%0d exp=14", bus.hazard_reg1); else passed++;
        drive(1, 7'd14, 0, 1, 0, 0, 0, 0);
        tick("post reset stall");
        checks++; if (bus.hazard_reg2 !== 7'd14) $display("FAIL prst_r2 got=%0d exp=14", bus.hazard_reg2); else passed++;
        RSTb = 1'b0;
        #1;
        checks++; if ({bus.hazard_reg2, bus.stall_p0} !== {7'd0, 1'b0})
            $display("FAIL midstall_rst got=%0d/%0b exp=0/0", bus.hazard_reg2, bus.stall_p0); else passed++;
        RSTb = 1'b1;
        drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
        tick("idle");
    endtask

`ifdef SLURM16_STALL_COUNT_EN
    task automatic test_stall_count();
        drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
        stall_count_clr = 1'b1;
        tick("cnt clear");
        stall_count_clr = 1'b0;
        checks++; if (stall_count !== 16'd0) $display("FAIL cnt_clr got=%0d exp=0", stall_count); else passed++;
        for (int k = 1; k <= 3; k++) begin
            drive(1, 7'd1, 0, 1, 0, 0, 0, 0);
            tick($sformatf("cnt stall%0d", k));
            checks++; if (stall_count !== 16'(k)) $display("FAIL cnt_inc%0d got=%0d exp=%0d", k, stall_count, k); else passed++;
        end
        drive(1, 7'd1, 0, 1, 0, 0, 0, 0);
        stall_count_clr = 1'b1;
        tick("cnt clr+hz");
        stall_count_clr = 1'b0;
        checks++; if (stall_count !== 16'd0) $display("FAIL cnt_clr_hz got=%0d exp=0", stall_count); else passed++;
        RSTb = 1'b0;
        drive(0, 7'd0, 0, 0, 0, 0, 0, 0);
        tick("cnt reset");
        RSTb = 1'b1;
    endtask
`endif

    initial begin
`ifdef SLURM16_STALL_COUNT_EN
        stall_count_clr = 1'b0;
`endif
        test_reset();
        test_raw_slot1();
        test_flag_hazard();
        test_flush_interlock();
        test_mem_wait_flush();
        test_fault_and_reset();
`ifdef SLURM16_STALL_COUNT_EN
        test_stall_count();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
